// File: rtl/note_player_pkg.sv
// Shared widths, state encodings and load payload for the note player.
package note_player_pkg;

  localparam int unsigned NOTE_W  = 6;
  localparam int unsigned DUR_W   = 6;
  localparam int unsigned PHASE_W = 22;
  localparam int unsigned STEP_W  = 20;

  localparam logic [NOTE_W-1:0] REST_NOTE = '0;

  // Player states
  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] PLAYING = 1'b1;

  // Note load payload from the song reader
  typedef struct packed {
    logic [NOTE_W-1:0] note;
    logic [DUR_W-1:0]  dur;
  } note_cmd_t;

endpackage

// File: rtl/note_player_frequency_rom.sv
// Note index to phase step: round(2^22 * 440 * 2^((n-49)/12) / 48000).
module note_player_frequency_rom #(
  parameter int unsigned STEP_W = 20
) (
  input  logic [5:0]        note,
  output logic [STEP_W-1:0] step_c
);
  import note_player_pkg::*;

  // Equal-tempered step table, A4 at index 49, index 0 is a rest
  always_comb begin
    step_c = '0;
    case (note)
      REST_NOTE: step_c = '0;
      6'd1:  step_c = STEP_W'(2403);
      6'd2:  step_c = STEP_W'(2546);
      6'd3:  step_c = STEP_W'(2697);
      6'd4:  step_c = STEP_W'(2858);
      6'd5:  step_c = STEP_W'(3028);
      6'd6:  step_c = STEP_W'(3208);
      6'd7:  step_c = STEP_W'(3398);
      6'd8:  step_c = STEP_W'(3600);
      6'd9:  step_c = STEP_W'(3815);
      6'd10: step_c = STEP_W'(4041);
      6'd11: step_c = STEP_W'(4282);
      6'd12: step_c = STEP_W'(4536);
      6'd13: step_c = STEP_W'(4806);
      6'd14: step_c = STEP_W'(5092);
      6'd15: step_c = STEP_W'(5395);
      6'd16: step_c = STEP_W'(5715);
      6'd17: step_c = STEP_W'(6055);
      6'd18: step_c = STEP_W'(6415);
      6'd19: step_c = STEP_W'(6797);
      6'd20: step_c = STEP_W'(7201);
      6'd21: step_c = STEP_W'(7629);
      6'd22: step_c = STEP_W'(8083);
      6'd23: step_c = STEP_W'(8563);
      6'd24: step_c = STEP_W'(9072);
      6'd25: step_c = STEP_W'(9612);
      6'd26: step_c = STEP_W'(10184);
      6'd27: step_c = STEP_W'(10789);
      6'd28: step_c = STEP_W'(11431);
      6'd29: step_c = STEP_W'(12110);
      6'd30: step_c = STEP_W'(12830);
      6'd31: step_c = STEP_W'(13593);
      6'd32: step_c = STEP_W'(14402);
      6'd33: step_c = STEP_W'(15258);
      6'd34: step_c = STEP_W'(16165);
      6'd35: step_c = STEP_W'(17127);
      6'd36: step_c = STEP_W'(18145);
      6'd37: step_c = STEP_W'(19224);
      6'd38: step_c = STEP_W'(20367);
      6'd39: step_c = STEP_W'(21578);
      6'd40: step_c = STEP_W'(22861);
      6'd41: step_c = STEP_W'(24221);
      6'd42: step_c = STEP_W'(25661);
      6'd43: step_c = STEP_W'(27187);
      6'd44: step_c = STEP_W'(28803);
      6'd45: step_c = STEP_W'(30516);
      6'd46: step_c = STEP_W'(32331);
      6'd47: step_c = STEP_W'(34253);
      6'd48: step_c = STEP_W'(36290);
      6'd49: step_c = STEP_W'(38448);
      6'd50: step_c = STEP_W'(40734);
      6'd51: step_c = STEP_W'(43156);
      6'd52: step_c = STEP_W'(45722);
      6'd53: step_c = STEP_W'(48441);
      6'd54: step_c = STEP_W'(51322);
      6'd55: step_c = STEP_W'(54373);
      6'd56: step_c = STEP_W'(57607);
      6'd57: step_c = STEP_W'(61032);
      6'd58: step_c = STEP_W'(64661);
      6'd59: step_c = STEP_W'(68506);
      6'd60: step_c = STEP_W'(72580);
      6'd61: step_c = STEP_W'(76896);
      6'd62: step_c = STEP_W'(81468);
      6'd63: step_c = STEP_W'(86312);
      default: step_c = '0;
    endcase
  end

endmodule

// File: rtl/note_player.sv
// Times one note against the beat strobe and advances the sine phase per sample request.
module note_player #(
  parameter int unsigned PHASE_W = 22,
  parameter int unsigned STEP_W  = 20
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              play_enable,
  input  logic [note_player_pkg::NOTE_W-1:0] note_to_load,
  input  logic [note_player_pkg::DUR_W-1:0]  duration_to_load,
  input  logic                              load_new_note,
  input  logic                              beat,
  input  logic                              generate_next_sample,
  output logic                              done_with_note,
  output logic [PHASE_W-1:0]                phase,
  output logic                              sample_ready,
  output logic                              mute
);
  import note_player_pkg::*;

  logic [0:0]         state, next_state;
  logic [DUR_W-1:0]   dur_q, dur_d;
  logic [STEP_W-1:0]  step_q, step_d, rom_step;
  logic [PHASE_W-1:0] phase_d;
  logic               done_d, sample_ready_d, mute_d;
  note_cmd_t          cmd;

  assign cmd = '{note: note_to_load, dur: duration_to_load};

  note_player_frequency_rom #(.STEP_W(STEP_W)) u_rom (
    .note   (cmd.note),
    .step_c (rom_step)
  );

  // Next-state and output decode; a load overrides beat and phase advance
  always_comb begin
    next_state     = state;
    dur_d          = dur_q;
    step_d         = step_q;
    phase_d        = phase;
    done_d         = 1'b0;
    sample_ready_d = generate_next_sample;
    mute_d         = (state == IDLE) | (step_q == '0) | ~play_enable;

    if (state == PLAYING && play_enable) begin
      if (dur_q == '0) begin
        done_d     = 1'b1;
        next_state = IDLE;
      end else if (beat && !load_new_note) begin
        dur_d = dur_q - DUR_W'(1);
      end
      if (generate_next_sample && !load_new_note) begin
        phase_d = phase + PHASE_W'(step_q);
      end
    end

    if (load_new_note) begin
      step_d     = rom_step;
      dur_d      = cmd.dur;
      phase_d    = '0;
      next_state = PLAYING;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      dur_q          <= '0;
      step_q         <= '0;
      phase          <= '0;
      done_with_note <= 1'b0;
      sample_ready   <= 1'b0;
      mute           <= 1'b1;
    end else begin
      state          <= next_state;
      dur_q          <= dur_d;
      step_q         <= step_d;
      phase          <= phase_d;
      done_with_note <= done_d;
      sample_ready   <= sample_ready_d;
      mute           <= mute_d;
    end
  end

endmodule

// File: tb/tb_note_player.sv
// Directed bench for note_player with a phase scoreboard popped on each sample_ready.
module tb_note_player;

  localparam longint MOD    = 64'd4194304;
  localparam longint STEP49 = 38448;
  localparam longint STEP63 = 86312;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        play_enable = 1'b0;
  logic [5:0]  note_to_load = '0;
  logic [5:0]  duration_to_load = '0;
  logic        load_new_note = 1'b0;
  logic        beat = 1'b0;
  logic        generate_next_sample = 1'b0;
  logic        done_with_note;
  logic [21:0] phase;
  logic        sample_ready;
  logic        mute;

  int     passed = 0;
  int     total = 0;
  int     done_cnt = 0;
  int     done_base = 0;
  longint exp_q[$];
  longint exp_phase = 0;
  longint cur_step = 0;
  longint raw = 0;
  int     extra = 0;

  note_player #(.PHASE_W(22), .STEP_W(20)) dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .play_enable          (play_enable),
    .note_to_load         (note_to_load),
    .duration_to_load     (duration_to_load),
    .load_new_note        (load_new_note),
    .beat                 (beat),
    .generate_next_sample (generate_next_sample),
    .done_with_note       (done_with_note),
    .phase                (phase),
    .sample_ready         (sample_ready),
    .mute                 (mute)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done_with_note === 1'b1) done_cnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic check_sample(input string tag);
    chk({tag, "_rdy"}, 64'(sample_ready), 64'd1);
    if (exp_q.size() == 0) begin
      total++;
      $error("FAIL %s: sample_ready with empty scoreboard, observed phase %0d", tag, phase);
    end else begin
      chk(tag, 64'(phase), 64'(exp_q.pop_front()));
    end
  endtask

  task automatic load(input int n, input int d, input longint step);
    note_to_load     = 6'(n);
    duration_to_load = 6'(d);
    load_new_note    = 1'b1;
    tick();
    load_new_note    = 1'b0;
    cur_step         = step;
    exp_phase        = 0;
  endtask

  task automatic req(input string tag);
    generate_next_sample = 1'b1;
    if (play_enable) exp_phase = (exp_phase + cur_step) % MOD;
    exp_q.push_back(exp_phase);
    tick();
    generate_next_sample = 1'b0;
    check_sample(tag);
  endtask

  task automatic beat_pulse();
    beat = 1'b1;
    tick();
    beat = 1'b0;
  endtask

  initial begin
    // reset state
    tick(); tick();
    chk("rst_phase", 64'(phase), 0);
    chk("rst_done", 64'(done_with_note), 0);
    chk("rst_rdy", 64'(sample_ready), 0);
    chk("rst_mute", 64'(mute), 1);
    reset_n = 1'b1;
    tick();

    // basic note: A4 for 3 beats
    play_enable = 1'b1;
    load(49, 3, STEP49);
    chk("load_phase", 64'(phase), 0);
    chk("load_mute_lag", 64'(mute), 1);
    tick();
    chk("play_mute", 64'(mute), 0);
    req("a4_req1");
    req("a4_req2");
    done_base = done_cnt;
    beat_pulse();
    beat_pulse();
    beat_pulse();
    chk("a4_done_early", 64'(done_with_note), 0);
    tick();
    chk("a4_done", 64'(done_with_note), 1);
    tick();
    chk("a4_done_end", 64'(done_with_note), 0);
    chk("a4_mute_end", 64'(mute), 1);
    chk("a4_done_cnt", 64'(done_cnt - done_base), 1);

    // pause: beats and requests ignored while disabled
    load(49, 2, STEP49);
    play_enable = 1'b0;
    tick();
    chk("pause_mute", 64'(mute), 1);
    done_base = done_cnt;
    for (int i = 0; i < 5; i++) begin
      beat = 1'b1;
      if (i < 4) begin
        generate_next_sample = 1'b1;
        exp_q.push_back(exp_phase);
      end
      tick();
      beat = 1'b0;
      generate_next_sample = 1'b0;
      if (i < 4) check_sample("pause_req");
    end
    tick();
    chk("pause_no_done", 64'(done_cnt - done_base), 0);
    play_enable = 1'b1;
    tick();
    req("resume_req");
    beat_pulse();
    tick();
    chk("resume_no_done", 64'(done_cnt - done_base), 0);
    beat_pulse();
    chk("resume_done_early", 64'(done_with_note), 0);
    tick();
    chk("resume_done", 64'(done_with_note), 1);
    tick();
    chk("resume_done_cnt", 64'(done_cnt - done_base), 1);

    // zero duration expires right after the load
    done_base = done_cnt;
    load(49, 0, STEP49);
    chk("dur0_early", 64'(done_with_note), 0);
    tick();
    chk("dur0_done", 64'(done_with_note), 1);
    tick();
    chk("dur0_end", 64'(done_with_note), 0);
    chk("dur0_cnt", 64'(done_cnt - done_base), 1);

    // load and beat together: beat is dropped
    done_base = done_cnt;
    note_to_load = 6'd49;
    duration_to_load = 6'd1;
    load_new_note = 1'b1;
    beat = 1'b1;
    tick();
    load_new_note = 1'b0;
    beat = 1'b0;
    tick(); tick();
    chk("ldbeat_no_done", 64'(done_cnt - done_base), 0);
    beat_pulse();
    chk("ldbeat_early", 64'(done_with_note), 0);
    tick();
    chk("ldbeat_done", 64'(done_with_note), 1);
    tick();
    chk("ldbeat_cnt", 64'(done_cnt - done_base), 1);

    // wrap: back-to-back requests on the highest note
    load(63, 60, STEP63);
    raw = 0;
    extra = 0;
    generate_next_sample = 1'b1;
    for (int i = 0; i < 80 && extra < 3; i++) begin
      raw = raw + STEP63;
      exp_phase = raw % MOD;
      exp_q.push_back(exp_phase);
      tick();
      check_sample("wrap_req");
      if (raw >= MOD) extra++;
    end
    generate_next_sample = 1'b0;
    chk("wrap_seen", 64'(extra), 3);

    // mid-note reset clears everything immediately
    req("pre_reset_req");
    done_base = done_cnt;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_phase", 64'(phase), 0);
    chk("mid_rst_done", 64'(done_with_note), 0);
    chk("mid_rst_rdy", 64'(sample_ready), 0);
    chk("mid_rst_mute", 64'(mute), 1);
    tick(); tick();
    chk("mid_rst_no_done", 64'(done_cnt - done_base), 0);
    reset_n = 1'b1;
    tick();
    chk("post_rst_phase", 64'(phase), 0);
    chk("post_rst_mute", 64'(mute), 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/note_player.md
# note_player

Downstream consumer of `song_reader`. It accepts one note at a time over the `note`/`duration`/`new_note` handshake and times it against a 48 Hz `beat` strobe. While the note sounds, it advances a phase accumulator once per sample request. When the duration expires it pulses `done_with_note` back to `song_reader`, which wires it to `note_done`. The phase it produces addresses the downstream sine lookup.

## Interface
Parameters:
- `PHASE_W`, default 22: phase accumulator width (2 quadrant + 10 address + 10 fraction bits).
- `STEP_W`, default 20: frequency step width.

Ports:
- `clk`  in  1: single system clock.
- `reset_n`  in  1: asynchronous, active-low reset.
- `play_enable`  in  1: high means run, low means freeze.
- `note_to_load`  in  6: note index; 0 is a rest.
- `duration_to_load`  in  6: note length in beats.
- `load_new_note`  in  1: one-cycle load strobe.
- `beat`  in  1: one-cycle strobe at 48 Hz.
- `generate_next_sample`  in  1: one-cycle sample request.
- `done_with_note`  out  1: one-cycle pulse when the current note expires.
- `phase`  out  PHASE_W: current phase.
- `sample_ready`  out  1: one-cycle pulse answering a sample request.
- `mute`  out  1: high when no audible note is active.

## Operation
- States:
  - IDLE: no note loaded.
  - PLAYING: note loaded and sounding.
- Reset values: state IDLE; `dur_q` 0; `step_q` 0; `phase` 0; `done_with_note` 0; `sample_ready` 0; `mute` 1.
- Load (`load_new_note`=1), accepted in any state:
  - `step_q` ← `frequency_rom(note_to_load)`.
  - `dur_q` ← `duration_to_load`.
  - `phase` ← 0.
  - State → PLAYING.
  - Load has priority over `beat` and phase advance in the same cycle.
- Beat, acting only in PLAYING with `play_enable`=1 and no load:
  - `dur_q` decrements by 1.
  - If `dur_q`==1 before the decrement: the next cycle asserts `done_with_note` for exactly 1 cycle and the state goes to IDLE.
- Duration 0 loaded: no beats are needed. `done_with_note` pulses on the cycle after the load and the state goes to IDLE.
- Sample request:
  - Every `generate_next_sample` produces a `sample_ready` pulse 1 cycle later, regardless of state or enable.
  - `phase` ← `phase` + `step_q` (mod 2^PHASE_W) only in PLAYING with `play_enable`=1 and no load. Otherwise `phase` holds.
- Pause: with `play_enable`=0, `dur_q` and `phase` freeze and beats are ignored. A load during pause is still accepted and stays frozen until enable returns.
- `mute` = (state==IDLE) | (`step_q`==0) | ~`play_enable`, registered.
- Width rules:
  - `step_q` is zero-extended to PHASE_W before the add.
  - The phase wraps silently.
  - `dur_q` never underflows; it never decrements below 0.
- Mid-operation reset: all state returns to reset values immediately, with no `done_with_note` pulse.

## Timing
- Load at edge N: new `phase`=0 and `step_q` are visible after edge N; `mute` updates after edge N+1.
- Beat that expires the note at edge N: `done_with_note` is high in the cycle after edge N+1, for 1 cycle only.
- Request at edge N: `phase` updated and `sample_ready` high after edge N; downstream samples both together.
- `done_with_note` and `load_new_note` may coincide: the load is processed and the state ends in PLAYING.

## Structure
Shared package `note_player_pkg`:
- `NOTE_W`=6, `DUR_W`=6, `PHASE_W`, `STEP_W`.
- `REST_NOTE`=0.
- State enum `{IDLE, PLAYING}`.

Sub-module `frequency_rom` (combinational):
- 64-entry lookup, 6-bit address, STEP_W data.
- Entry 0 = 0.
- Entry n = round(2^22 · 440 · 2^((n−49)/12) / 48000); entry 49 = 38448 (A4).

## Test plan
- Reset: assert `reset_n`=0 mid-note → `phase`=0, `done_with_note`=0, `sample_ready`=0, `mute`=1 immediately.
- Load note 49, duration 3, `play_enable`=1; 2 sample requests → `phase`=38448 then 76896, each with a `sample_ready` pulse. Then 3 beats → a single `done_with_note` pulse the cycle after the 3rd beat's edge, then `mute`=1.
- Pause: load note 49, duration 2; drop `play_enable` for 5 beats and 4 requests → `phase` and `dur_q` unchanged, 4 `sample_ready` pulses, no done. Re-enable and send 2 beats → done.
- Duration 0 load → `done_with_note` pulses exactly 1 cycle after the load.
- `load_new_note` and `beat` in the same cycle (duration 1 loaded) → beat ignored; done arrives only after the next beat.
- Wrap: load note 63, issue requests until `phase` exceeds 2^22−1 → value equals the sum mod 2^22, with no stall.
